traffic_ctrl_nway: RTL and testbench
====================================

# traffic_ctrl_nway

Parametrised N-approach traffic-light controller: one approach is green at a time, and the other approaches sit red until served. It enforces a minimum green time, a fixed yellow phase and an optional all-red clearance phase. Contested approaches are served round-robin, and an optional maximum-green limit forces a handover when cross traffic is waiting. It is the intersection-level successor to the two-street controller and drives the light outputs of the lab board directly.

## Interface
- N_WAY, 4: number of approaches (≥2).
- MIN_GREEN, 2: minimum cycles an approach shows green (≥1).
- YELLOW_CYC, 1: cycles of yellow (≥1).
- ALLRED_CYC, 1: cycles of all-red clearance after yellow (0 = phase skipped).
- MAX_GREEN, 6: maximum green cycles while any other approach requests (0 = unlimited; otherwise ≥MIN_GREEN).
- CNT_W, 4: phase timer width; 2^CNT_W−1 ≥ max(MIN_GREEN, YELLOW_CYC, ALLRED_CYC, MAX_GREEN).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- car  input  N_WAY  car[i]=1 means a vehicle is waiting or present on approach i. Sampled each edge; no synchronisation inside the block.
- light  output  3*N_WAY  approach i occupies bits [3i+2:3i], one-hot: RED=3'b100, YELLOW=3'b010, GREEN=3'b001. Registered.
- active  output  max(1,$clog2(N_WAY))  index of the approach currently green/yellow. Registered.
- phase  output  2  0=GREEN, 1=YELLOW, 2=ALLRED. Registered; value 3 never occurs.

## Operation
- State: phase, active, next_idx, timer (CNT_W bits).
- Reset (async, immediate, including mid-phase): phase=GREEN, active=0, next_idx=0, timer=0. light shows approach 0 GREEN and all others RED.
- Timer: cleared on every phase entry and incremented each cycle within a phase, saturating at 2^CNT_W−1. The value t is 0 in the first cycle of a phase.
- other_req = OR of car[j] over j≠active.
- GREEN: leave at the next edge iff t+1 ≥ MIN_GREEN, other_req=1, and either:
  - car[active]=0, or
  - MAX_GREEN≠0 and t+1 ≥ MAX_GREEN.
- Otherwise GREEN holds. This covers no cars anywhere and only the active approach requesting.
- On leaving GREEN:
  - next_idx is latched to the first j with car[j]=1, searching active+1, active+2, … modulo N_WAY and excluding active.
  - Phase goes to YELLOW.
- YELLOW: active approach shows YELLOW and all others RED. After YELLOW_CYC cycles (t+1=YELLOW_CYC), go to ALLRED, or straight to GREEN when ALLRED_CYC=0.
- ALLRED: every approach shows RED. After ALLRED_CYC cycles, go to GREEN.
- Entering GREEN: active←next_idx and timer←0.
- During YELLOW/ALLRED, car is ignored. The latched target is served even if its request drops.
- Non-active approaches are always RED. Exactly one bit is set in each 3-bit light field at all times.

## Timing
- Outputs change only on clk rising edge or asynchronously on rst assertion.
- Latency from the decision edge: first YELLOW cycle follows immediately.
- Handover, measured from the last green cycle of the old approach to the first green cycle of the new one, takes YELLOW_CYC+ALLRED_CYC+1 edges.
- Minimum dwell: an approach shows GREEN for ≥MIN_GREEN consecutive cycles, including right after reset.
- Under continuous cross traffic with MAX_GREEN≠0, green lasts exactly MAX_GREEN cycles.
- car[active] toggling during GREEN only affects the leave decision on the cycle it is sampled.
- car changing on the same edge as the decision uses the value sampled at that edge.

## Test plan
- Reset with car=0 held for 20 cycles, defaults → light=12'b100_100_100_001, active=0, phase=0 throughout. Assert rst mid-YELLOW → outputs return to the same values immediately, without waiting for a clock edge.
- Release reset with car=4'b0100 held → approach 0 is GREEN for cycles 0–1, YELLOW for cycle 2, all RED for cycle 3, and approach 2 is GREEN (active=2) from cycle 4.
- Active=1 GREEN, car=4'b1001 → next_idx=3 (not 0). Approach 3 is served, then on return approach 0 is served.
- Active=0, car=4'b0011 held → approach 0 GREEN for exactly 6 cycles, then YELLOW/ALLRED, then approach 1 GREEN for 6 cycles, then back to 0.
- MAX_GREEN=0, car=4'b0011 held → approach 0 stays GREEN indefinitely (check 50 cycles).
- ALLRED_CYC=0, YELLOW_CYC=3, car=4'b0010 → approach 0 GREEN for 2 cycles, then YELLOW for 3 cycles, phase never equals 2, and approach 1 is GREEN on the next cycle. Drop car during YELLOW → approach 1 is still served.

Source files
------------

// File: rtl/traffic_ctrl_nway_if.sv
// Light-controller bundle: car requests in, per-approach one-hot lights and status out.
// The controller side uses 'master'; the board/sensor side uses 'slave'.
interface traffic_ctrl_nway_if #(
    parameter int N_WAY = 4
);
    localparam int AW = ($clog2(N_WAY) < 1) ? 1 : $clog2(N_WAY);

    logic [N_WAY-1:0]   car;
    logic [3*N_WAY-1:0] light;
    logic [AW-1:0]      active;
    logic [1:0]         phase;

    modport master (input car, output light, output active, output phase);
    modport slave  (output car, input light, input active, input phase);
endinterface

// File: rtl/traffic_ctrl_nway.sv
// N-approach traffic light: min/max green, yellow, optional all-red, round-robin handover.
// Outputs are registered (one edge from decision); car is a level request, never stalled.
module traffic_ctrl_nway #(
    parameter int N_WAY      = 4,
    parameter int MIN_GREEN  = 2,
    parameter int YELLOW_CYC = 1,
    parameter int ALLRED_CYC = 1,
    parameter int MAX_GREEN  = 6,
    parameter int CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_ctrl_nway_if.master  lights
);
    localparam int AW = ($clog2(N_WAY) < 1) ? 1 : $clog2(N_WAY);

    localparam logic [1:0] PH_GREEN  = 2'd0;
    localparam logic [1:0] PH_YELLOW = 2'd1;
    localparam logic [1:0] PH_ALLRED = 2'd2;

    localparam logic [CNT_W:0] MIN_G = (CNT_W+1)'(MIN_GREEN);
    localparam logic [CNT_W:0] MAX_G = (CNT_W+1)'(MAX_GREEN);
    localparam logic [CNT_W:0] YEL_C = (CNT_W+1)'(YELLOW_CYC);
    localparam logic [CNT_W:0] AR_C  = (CNT_W+1)'(ALLRED_CYC);

    localparam logic [3*N_WAY-1:0] LIGHT_RST = {{(N_WAY-1){3'b100}}, 3'b001};

    logic [1:0]         phaseQ, phaseD;
    logic [AW-1:0]      activeQ, activeD;
    logic [AW-1:0]      nextIdxQ, nextIdxD;
    logic [AW-1:0]      searchIdx;
    logic [CNT_W-1:0]   timerQ, timerD;
    logic [CNT_W:0]     tPlus1;
    logic [N_WAY-1:0]   activeMask;
    logic               otherReq, activeReq, leaveGreen;
    logic [3*N_WAY-1:0] lightQ, lightD;
    logic [AW:0]        candIdx;

    assign activeMask = {{(N_WAY-1){1'b0}}, 1'b1} << activeQ;
    assign otherReq   = |(lights.car & ~activeMask);
    assign activeReq  = |(lights.car & activeMask);
    assign tPlus1     = {1'b0, timerQ} + 1'b1;

    assign leaveGreen = (tPlus1 >= MIN_G) && otherReq &&
                        (!activeReq || ((MAX_GREEN != 0) && (tPlus1 >= MAX_G)));

    // Descending scan so the nearest requester after the active one wins.
    always_comb begin
        searchIdx = '0;
        candIdx   = '0;
        for (int k = N_WAY-1; k >= 1; k--) begin
            candIdx = {1'b0, activeQ} + (AW+1)'(k);
            if (candIdx >= (AW+1)'(N_WAY))
                candIdx = candIdx - (AW+1)'(N_WAY);
            if (lights.car[candIdx[AW-1:0]])
                searchIdx = candIdx[AW-1:0];
        end
    end

    always_comb begin
        phaseD   = phaseQ;
        activeD  = activeQ;
        nextIdxD = nextIdxQ;
        case (phaseQ)
            PH_GREEN: begin
                if (leaveGreen) begin
                    phaseD   = PH_YELLOW;
                    nextIdxD = searchIdx;
                end
            end
            PH_YELLOW: begin
                if (tPlus1 >= YEL_C) begin
                    if (ALLRED_CYC == 0) begin
                        phaseD  = PH_GREEN;
                        activeD = nextIdxQ;
                    end else begin
                        phaseD  = PH_ALLRED;
                    end
                end
            end
            PH_ALLRED: begin
                if (tPlus1 >= AR_C) begin
                    phaseD  = PH_GREEN;
                    activeD = nextIdxQ;
                end
            end
            default: begin
                phaseD = PH_GREEN;
            end
        endcase
    end

    // Every phase entry changes the phase code, so a change marks a new phase.
    always_comb begin
        timerD = timerQ;
        if (phaseD != phaseQ)
            timerD = '0;
        else if (timerQ != {CNT_W{1'b1}})
            timerD = timerQ + 1'b1;
    end

    always_comb begin
        lightD = '0;
        for (int i = 0; i < N_WAY; i++) begin
            lightD[3*i +: 3] = 3'b100;
            if (AW'(i) == activeD) begin
                if (phaseD == PH_GREEN)
                    lightD[3*i +: 3] = 3'b001;
                else if (phaseD == PH_YELLOW)
                    lightD[3*i +: 3] = 3'b010;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phaseQ   <= PH_GREEN;
            activeQ  <= '0;
            nextIdxQ <= '0;
            timerQ   <= '0;
            lightQ   <= LIGHT_RST;
        end else begin
            phaseQ   <= phaseD;
            activeQ  <= activeD;
            nextIdxQ <= nextIdxD;
            timerQ   <= timerD;
            lightQ   <= lightD;
        end
    end

    assign lights.light  = lightQ;
    assign lights.active = activeQ;
    assign lights.phase  = phaseQ;
endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed bench for traffic_ctrl_nway: cycle tables on the default build, hand sequences
// for async reset, unlimited green and the no-all-red/long-yellow build.
module tb_traffic_ctrl_nway;
    logic clk;
    logic rst0, rst1, rst2;
    int   checks;
    int   errors;

    localparam logic [11:0] G0 = 12'b100_100_100_001;
    localparam logic [11:0] Y0 = 12'b100_100_100_010;
    localparam logic [11:0] AR = 12'b100_100_100_100;
    localparam logic [11:0] G1 = 12'b100_100_001_100;
    localparam logic [11:0] Y1 = 12'b100_100_010_100;
    localparam logic [11:0] G2 = 12'b100_001_100_100;
    localparam logic [11:0] Y2 = 12'b100_010_100_100;
    localparam logic [11:0] G3 = 12'b001_100_100_100;
    localparam logic [11:0] Y3 = 12'b010_100_100_100;

    traffic_ctrl_nway_if #(.N_WAY(4)) bus0 ();
    traffic_ctrl_nway_if #(.N_WAY(4)) bus1 ();
    traffic_ctrl_nway_if #(.N_WAY(4)) bus2 ();

    traffic_ctrl_nway #(.N_WAY(4), .MIN_GREEN(2), .YELLOW_CYC(1), .ALLRED_CYC(1),
                        .MAX_GREEN(6), .CNT_W(4))
        dut0 (.clk(clk), .rst(rst0), .lights(bus0.master));

    traffic_ctrl_nway #(.N_WAY(4), .MIN_GREEN(2), .YELLOW_CYC(1), .ALLRED_CYC(1),
                        .MAX_GREEN(0), .CNT_W(4))
        dut1 (.clk(clk), .rst(rst1), .lights(bus1.master));

    traffic_ctrl_nway #(.N_WAY(4), .MIN_GREEN(2), .YELLOW_CYC(3), .ALLRED_CYC(0),
                        .MAX_GREEN(6), .CNT_W(4))
        dut2 (.clk(clk), .rst(rst2), .lights(bus2.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  car;
        logic [11:0] light;
        logic [1:0]  active;
        logic [1:0]  phase;
        int          reps;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int     cyc;
        bit     found;
        logic [11:0] expL;
        logic [1:0]  expA, expP;

        checks = 0;
        errors = 0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        bus0.car = 4'b0000; bus1.car = 4'b0000; bus2.car = 4'b0000;

        // {car applied after the check, light, active, phase, consecutive cycles}
        vecs[0]  = '{4'b0100, G0, 2'd0, 2'd0, 2};
        vecs[1]  = '{4'b0100, Y0, 2'd0, 2'd1, 1};
        vecs[2]  = '{4'b0100, AR, 2'd0, 2'd2, 1};
        vecs[3]  = '{4'b0010, G2, 2'd2, 2'd0, 2};
        vecs[4]  = '{4'b0010, Y2, 2'd2, 2'd1, 1};
        vecs[5]  = '{4'b0010, AR, 2'd2, 2'd2, 1};
        vecs[6]  = '{4'b1001, G1, 2'd1, 2'd0, 2};
        vecs[7]  = '{4'b1001, Y1, 2'd1, 2'd1, 1};
        vecs[8]  = '{4'b1001, AR, 2'd1, 2'd2, 1};
        vecs[9]  = '{4'b1001, G3, 2'd3, 2'd0, 6};
        vecs[10] = '{4'b1001, Y3, 2'd3, 2'd1, 1};
        vecs[11] = '{4'b1001, AR, 2'd3, 2'd2, 1};
        vecs[12] = '{4'b0011, G0, 2'd0, 2'd0, 6};
        vecs[13] = '{4'b0011, Y0, 2'd0, 2'd1, 1};
        vecs[14] = '{4'b0011, AR, 2'd0, 2'd2, 1};
        vecs[15] = '{4'b0011, G1, 2'd1, 2'd0, 6};
        vecs[16] = '{4'b0011, Y1, 2'd1, 2'd1, 1};
        vecs[17] = '{4'b0011, AR, 2'd1, 2'd2, 1};
        vecs[18] = '{4'b0011, G0, 2'd0, 2'd0, 1};

        // Held reset with no cars.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("rst_light[%0d]", c), 32'(bus0.light), 32'(G0));
            chk($sformatf("rst_active[%0d]", c), 32'(bus0.active), 32'd0);
            chk($sformatf("rst_phase[%0d]", c), 32'(bus0.phase), 32'd0);
        end

        // Release with car on approach 2, then walk the round-robin table.
        bus0.car = 4'b0100;
        rst0 = 1'b0;
        cyc = 0;
        for (int v = 0; v < 19; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                chk($sformatf("tbl_light[c%0d]", cyc), 32'(bus0.light), 32'(vecs[v].light));
                chk($sformatf("tbl_active[c%0d]", cyc), 32'(bus0.active), 32'(vecs[v].active));
                chk($sformatf("tbl_phase[c%0d]", cyc), 32'(bus0.phase), 32'(vecs[v].phase));
                bus0.car = vecs[v].car;
                @(negedge clk);
                cyc++;
            end
        end

        // Run to the next yellow, then assert reset between clock edges.
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus0.phase == 2'd1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_yellow", 32'(found), 32'd1);
        chk("yellow_light", 32'(bus0.light), 32'(Y0));
        #2 rst0 = 1'b1;
        #1;
        chk("async_rst_light", 32'(bus0.light), 32'(G0));
        chk("async_rst_active", 32'(bus0.active), 32'd0);
        chk("async_rst_phase", 32'(bus0.phase), 32'd0);
        @(negedge clk);
        chk("held_rst_light", 32'(bus0.light), 32'(G0));
        chk("held_rst_phase", 32'(bus0.phase), 32'd0);

        // Unlimited green: approach 0 keeps green while both 0 and 1 request.
        bus1.car = 4'b0011;
        rst1 = 1'b0;
        for (int c = 0; c < 50; c++) begin
            chk($sformatf("nomax_light[c%0d]", c), 32'(bus1.light), 32'(G0));
            chk($sformatf("nomax_phase[c%0d]", c), 32'(bus1.phase), 32'd0);
            @(negedge clk);
        end

        // No all-red, 3-cycle yellow; request dropped mid-yellow is still served.
        bus2.car = 4'b0010;
        rst2 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c < 2) begin
                expL = G0; expA = 2'd0; expP = 2'd0;
            end else if (c < 5) begin
                expL = Y0; expA = 2'd0; expP = 2'd1;
            end else begin
                expL = G1; expA = 2'd1; expP = 2'd0;
            end
            chk($sformatf("noar_light[c%0d]", c), 32'(bus2.light), 32'(expL));
            chk($sformatf("noar_active[c%0d]", c), 32'(bus2.active), 32'(expA));
            chk($sformatf("noar_phase[c%0d]", c), 32'(bus2.phase), 32'(expP));
            if (c == 3)
                bus2.car = 4'b0000;
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
